// File: rtl/seq_right_shifter.sv
// seq_right_shifter: iterative right shift / arithmetic shift / rotate unit.
// Accepts one request over a valid/ready handshake. The operand then moves one
// bit position per clock. The result and the last bit shifted out are held on a
// second valid/ready handshake until the consumer takes them.
module seq_right_shifter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             fill_bit;
    logic             accept;

    // Handshake decodes depend only on registered state, plus rst for in_ready
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign accept    = in_valid && in_ready;

    // Bit entering at the MSB for one shift step; modes 10 and 11 both rotate
    always_comb begin
        fill_bit = data_q[0];
        case (mode_q)
            MODE_LSR: fill_bit = 1'b0;
            MODE_ASR: fill_bit = data_q[WIDTH-1];
            default:  fill_bit = data_q[0];
        endcase
    end

    // Next-state logic for the FSM and datapath registers
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    carry_d = 1'b0;
                    cnt_d   = in_amt;
                    mode_d  = in_mode;
                    state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d  = {fill_bit, data_q[WIDTH-1:1]};
                carry_d = data_q[0];
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result stays put; no new request is taken on the consume edge
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_LSR;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter with a scoreboard of expected results.
module tb_seq_right_shifter;

    localparam int unsigned W = 4;
    localparam int unsigned A = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [A-1:0] in_amt;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_carry;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] sb_q[$];

    seq_right_shifter #(.WIDTH(W), .AMT_W(A)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {carry, data} computed directly, not step by step
    function automatic logic [W:0] model(input logic [W-1:0] d, input int a,
                                         input logic [1:0] m);
        logic [W-1:0] r;
        logic         c;
        c = (a == 0) ? 1'b0 : d[a-1];
        if (m == 2'b00)      r = d >> a;
        else if (m == 2'b01) r = $signed(d) >>> a;
        else                 r = (d >> a) | (d << (W - a));
        return {c, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for in_ready, let it be accepted
    task automatic send(input logic [W-1:0] d, input logic [A-1:0] a, input logic [1:0] m,
                        input bit track);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        k = 0;
        while (!in_ready && k < 20) begin
            cyc();
            k++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = ~a;
        in_mode  = 2'b00;
        if (track) sb_q.push_back(model(d, int'(a), m));
    endtask

    // Wait (bounded) for out_valid, check latency and pop/compare the scoreboard
    task automatic get_result(input string tag, input int lat);
        int n;
        logic [W:0] e;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_data"}, 32'(out_data), 32'(e[W-1:0]));
            chk({tag, "_carry"}, 32'(out_carry), 32'(e[W]));
        end
    endtask

    initial begin
        logic [W-1:0] held_d;
        logic         held_c;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = 2'b00;
        out_ready = 1'b1;

        // Reset state
        cyc();
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        cyc();

        // Logical: 1011 >> 2 -> 0010, carry 1, valid for one cycle
        send(4'b1011, 2'd2, 2'b00, 1'b1);
        chk("lsr_busy", 32'(busy), 32'd1);
        get_result("lsr", 2);
        cyc();
        chk("lsr_one_cycle", 32'(out_valid), 32'd0);
        chk("lsr_idle_ready", 32'(in_ready), 32'd1);

        // Arithmetic, amt=W-1
        send(4'b1000, 2'd3, 2'b01, 1'b1);
        get_result("asr_neg", 3);
        cyc();
        send(4'b0111, 2'd3, 2'b01, 1'b1);
        get_result("asr_pos", 3);
        cyc();

        // Rotate and reserved mode
        send(4'b0001, 2'd1, 2'b10, 1'b1);
        get_result("ror", 1);
        cyc();
        send(4'b0001, 2'd1, 2'b11, 1'b1);
        get_result("ror11", 1);
        cyc();
        send(4'b1101, 2'd3, 2'b10, 1'b1);
        get_result("ror_w1", 3);
        cyc();
        send(4'b1101, 2'd3, 2'b00, 1'b1);
        get_result("lsr_w1", 3);
        cyc();

        // Zero amount
        send(4'b0110, 2'd0, 2'b00, 1'b1);
        chk("zero_in_ready_done", 32'(in_ready), 32'd0);
        get_result("zero", 0);
        cyc();
        chk("zero_ready_after", 32'(in_ready), 32'd1);

        // Backpressure with an ignored request while DONE
        out_ready = 1'b0;
        send(4'b1011, 2'd1, 2'b00, 1'b1);
        get_result("bp", 1);
        held_d = out_data;
        held_c = out_carry;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                in_data  = 4'b1111;
                in_amt   = 2'd0;
                in_mode  = 2'b01;
            end
            if (i == 2) in_valid = 1'b0;
            cyc();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'(held_d));
            chk("bp_carry", 32'(out_carry), 32'(held_c));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_released", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);
        cyc();
        cyc();
        chk("bp_no_ghost", 32'(busy), 32'd0);

        // Reset mid-SHIFT discards the in-flight result
        send(4'b1000, 2'd3, 2'b01, 1'b0);
        cyc();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_data", 32'(out_data), 32'd0);
        chk("mid_busy_clr", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("mid_no_result", 32'(out_valid), 32'd0);
        end
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
